timing_controller_multiframe: RTL and testbench
===============================================

Name: timing_controller_multiframe

Overview:
Parametrised successor to the single-mode SLM timing controller. It sequences line transfers from the DC32 input FIFO into the display line clocker across a configurable frame geometry. At each frame end it issues a programmable-length update pulse and drives DC-balance inversion every INVERT_PERIOD frames. It sits between the DC32 FIFO/line buffer and the pixel line clocker, and adds a line-starvation watchdog with a sticky error flag.

Parameters:
BUF_CNT_W, 7, width of num_words_in_buffer
WORDS_PER_LINE, 64, words required in buffer before a line is released; must be ≤ 2^BUF_CNT_W-1
LINES_PER_FRAME, 1280, lines per frame; ≥ 1
LINE_IDX_W, 11, width of line_index; 2^LINE_IDX_W ≥ LINES_PER_FRAME
UPDATE_CYCLES, 4, length of update pulse in clocks; ≥ 1
INVERT_PERIOD, 1, frames between invert toggles; ≥ 1
LINE_TIMEOUT, 4096, max clocks waiting for a line before error; ≥ 2
FRAME_CNT_W, 16, width of frame_count

Ports:
fpga_clk  in  1  system clock, all logic rising-edge
reset_all  in  1  asynchronous active-high reset
enable  in  1  run request; sampled at frame boundaries
num_words_in_buffer  in  BUF_CNT_W  current line-buffer fill level
dc32_fifo_is_empty  in  1  DC32 input FIFO empty
line_done  in  1  one-cycle pulse from line clocker: line consumed
next_line_clock_into_fifo  out  1  one-cycle request to clock next line into buffer
line_of_data_available  out  1  level: full line ready for clocker
start_clocking_frame_data_cmd  out  1  one-cycle pulse at frame start
update  out  1  frame-end update strobe, UPDATE_CYCLES long
invert  out  1  DC-balance polarity
line_index  out  LINE_IDX_W  index of current line
frame_count  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W
underrun_err  out  1  sticky starvation error

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal counters 0.
- All outputs registered; no combinational input-to-output path.
- IDLE: when enable=1, next cycle: start_clocking_frame_data_cmd=1 (1 clk), line_index=0, enter REQ.
- REQ: next_line_clock_into_fifo=1 for exactly 1 clk; timeout counter cleared; enter WAIT.
- WAIT: timeout counter increments every clock.
  - If num_words_in_buffer ≥ WORDS_PER_LINE: line_of_data_available=1 from the next cycle; enter SEND.
  - Else, if the timeout counter reaches LINE_TIMEOUT-1: underrun_err=1 (sticky until reset); line_of_data_available=0; line_index=0; enter IDLE. No update is issued.
  - The fill test has priority over timeout on the same cycle.
  - dc32_fifo_is_empty does not block; it only gates the watchdog: the counter holds while dc32_fifo_is_empty=0 and num_words_in_buffer is increasing versus the previous cycle.
- SEND: line_of_data_available held 1 until a line_done pulse.
  - On line_done: line_of_data_available=0 next cycle.
  - If line_index = LINES_PER_FRAME-1, enter UPD; else line_index+1 and enter REQ.
  - line_done in any other state is ignored.
- UPD: update=1 for exactly UPDATE_CYCLES clocks. On the last cycle:
  - frame_count+1.
  - Frame-since-toggle counter +1; when it reaches INVERT_PERIOD, invert toggles and the counter clears.
  - invert changes on the same edge that update falls.
  - Then: if enable=1, pulse start_clocking_frame_data_cmd, line_index=0, enter REQ (zero idle cycles between frames); else enter IDLE.
- enable deasserted mid-frame: current frame completes, including UPD; IDLE follows.
- underrun_err does not prevent restart. IDLE with enable=1 starts a new frame and the flag stays 1.
- invert and frame_count are not cleared on timeout or IDLE; only reset clears them.
- Latency: fill condition to line_of_data_available = 1 clk; last line_done to update rise = 1 clk.

Test Plan:
(Params for 1–4: WORDS_PER_LINE=4, LINES_PER_FRAME=3, UPDATE_CYCLES=2, INVERT_PERIOD=1.)
1. Reset, enable=1, num_words held at 4, line_done pulsed 2 clk after each line_of_data_available rise. Expect: one start pulse; 3 next_line_clock_into_fifo pulses; line_index 0,1,2; update high 2 clk; invert 0→1; frame_count=1.
2. Continue enable=1 for 3 frames. Expect invert sequence 1,0,1; frame_count=4. Next start pulse the clock after update falls.
3. num_words held at 3 for 10 clk, then 4. Expect no line_of_data_available until 1 clk after fill reaches 4; no watchdog error with LINE_TIMEOUT=4096.
4. LINE_TIMEOUT=8, num_words=0, dc32_fifo_is_empty=1. Expect underrun_err=1 after 8 WAIT clocks; state IDLE; line_index=0. The flag persists across a subsequent successful frame.
5. enable dropped during line 1 of 3. Expect lines 1–2 and update to complete, then IDLE with no further start pulse. Also inject line_done pulses in REQ/WAIT; expect them to be ignored.
6. Assert reset_all mid-SEND, asynchronously between edges. Expect all outputs 0 immediately. After release, expect no activity until enable is sampled.

Source files
------------

// File: rtl/timing_controller_multiframe.sv
// Frame sequencer between the DC32 line buffer and the pixel line clocker:
// requests/releases lines, issues the frame-end update strobe, DC-balance inversion and a starvation watchdog.
module timing_controller_multiframe #(
  parameter int BUF_CNT_W       = 7,
  parameter int WORDS_PER_LINE  = 64,
  parameter int LINES_PER_FRAME = 1280,
  parameter int LINE_IDX_W      = 11,
  parameter int UPDATE_CYCLES   = 4,
  parameter int INVERT_PERIOD   = 1,
  parameter int LINE_TIMEOUT    = 4096,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                   fpga_clk,
  input  logic                   reset_all,
  input  logic                   enable,
  input  logic [BUF_CNT_W-1:0]   num_words_in_buffer,
  input  logic                   dc32_fifo_is_empty,
  input  logic                   line_done,
  output logic                   next_line_clock_into_fifo,
  output logic                   line_of_data_available,
  output logic                   start_clocking_frame_data_cmd,
  output logic                   update,
  output logic                   invert,
  output logic [LINE_IDX_W-1:0]  line_index,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   underrun_err
);

  localparam int TO_W = $clog2(LINE_TIMEOUT);
  localparam int UC_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam int FT_W = (INVERT_PERIOD > 1) ? $clog2(INVERT_PERIOD) : 1;

  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(LINE_TIMEOUT - 1);
  localparam logic [UC_W-1:0]       UC_LAST   = UC_W'(UPDATE_CYCLES - 1);
  localparam logic [FT_W-1:0]       FT_LAST   = FT_W'(INVERT_PERIOD - 1);
  localparam logic [LINE_IDX_W-1:0] LAST_LINE = LINE_IDX_W'(LINES_PER_FRAME - 1);
  localparam logic [BUF_CNT_W-1:0]  FILL_LVL  = BUF_CNT_W'(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_UPD  = 3'd4
  } state_t;

  state_t                 state_r, state_s;
  logic [LINE_IDX_W-1:0]  line_index_r, line_index_s;
  logic [TO_W-1:0]        to_cnt_r, to_cnt_s;
  logic [UC_W-1:0]        upd_cnt_r, upd_cnt_s;
  logic [FT_W-1:0]        ft_cnt_r, ft_cnt_s;
  logic [FRAME_CNT_W-1:0] frame_count_r, frame_count_s;
  logic [BUF_CNT_W-1:0]   prev_words_r;
  logic                   invert_r, invert_s;
  logic                   err_r, err_s;
  logic                   start_s;
  logic                   req_r, lda_r, start_r, update_r;
  logic                   fill_s, hold_s;

  assign fill_s = (num_words_in_buffer >= FILL_LVL);
  // A non-empty FIFO that is still filling the buffer is progress, not starvation.
  assign hold_s = !dc32_fifo_is_empty && (num_words_in_buffer > prev_words_r);

  // Next-state and next-value logic for the frame sequencer.
  always_comb begin
    state_s       = state_r;
    line_index_s  = line_index_r;
    to_cnt_s      = to_cnt_r;
    upd_cnt_s     = upd_cnt_r;
    ft_cnt_s      = ft_cnt_r;
    frame_count_s = frame_count_r;
    invert_s      = invert_r;
    err_s         = err_r;
    start_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (enable) begin
          state_s      = S_REQ;
          start_s      = 1'b1;
          line_index_s = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        to_cnt_s = '0;
        state_s  = S_WAIT;
      end
      S_WAIT: begin
        if (fill_s) begin
          state_s = S_SEND;
        end else if (hold_s) begin
          to_cnt_s = to_cnt_r;
        end else if (to_cnt_r == TO_LAST) begin
          err_s        = 1'b1;
          line_index_s = '0;
          state_s      = S_IDLE;
        end else begin
          to_cnt_s = to_cnt_r + TO_W'(1);
        end
      end
      S_SEND: begin
        if (line_done) begin
          if (line_index_r == LAST_LINE) begin
            upd_cnt_s = '0;
            state_s   = S_UPD;
          end else begin
            line_index_s = line_index_r + LINE_IDX_W'(1);
            state_s      = S_REQ;
          end
        end else begin
          state_s = S_SEND;
        end
      end
      S_UPD: begin
        if (upd_cnt_r == UC_LAST) begin
          frame_count_s = frame_count_r + FRAME_CNT_W'(1);
          if (ft_cnt_r == FT_LAST) begin
            invert_s = !invert_r;
            ft_cnt_s = '0;
          end else begin
            ft_cnt_s = ft_cnt_r + FT_W'(1);
          end
          // enable is only sampled here and in IDLE, so frames never truncate.
          if (enable) begin
            start_s      = 1'b1;
            line_index_s = '0;
            state_s      = S_REQ;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          upd_cnt_s = upd_cnt_r + UC_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state so they align with it.
  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) begin
      state_r       <= S_IDLE;
      line_index_r  <= '0;
      to_cnt_r      <= '0;
      upd_cnt_r     <= '0;
      ft_cnt_r      <= '0;
      frame_count_r <= '0;
      prev_words_r  <= '0;
      invert_r      <= 1'b0;
      err_r         <= 1'b0;
      req_r         <= 1'b0;
      lda_r         <= 1'b0;
      start_r       <= 1'b0;
      update_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      line_index_r  <= line_index_s;
      to_cnt_r      <= to_cnt_s;
      upd_cnt_r     <= upd_cnt_s;
      ft_cnt_r      <= ft_cnt_s;
      frame_count_r <= frame_count_s;
      prev_words_r  <= num_words_in_buffer;
      invert_r      <= invert_s;
      err_r         <= err_s;
      req_r         <= (state_s == S_REQ);
      lda_r         <= (state_s == S_SEND);
      start_r       <= start_s;
      update_r      <= (state_s == S_UPD);
    end
  end

  assign next_line_clock_into_fifo     = req_r;
  assign line_of_data_available        = lda_r;
  assign start_clocking_frame_data_cmd = start_r;
  assign update                        = update_r;
  assign invert                        = invert_r;
  assign line_index                    = line_index_r;
  assign frame_count                   = frame_count_r;
  assign underrun_err                  = err_r;

endmodule

// File: tb/tb_timing_controller_multiframe.sv
// Self-checking bench: reset/frame vector table, directed corner sequences and random stimulus
// compared against a behavioural frame model.
module tb_timing_controller_multiframe;

  localparam int BW = 4, WPL = 4, LPF = 3, IW = 2, UC = 2, IP = 1, LT = 12, FW = 16;
  localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_SEND = 3, P_UPD = 4;

  logic          fpga_clk = 1'b0;
  logic          reset_all = 1'b1;
  logic          enable = 1'b0;
  logic [BW-1:0] num_words_in_buffer = '0;
  logic          dc32_fifo_is_empty = 1'b0;
  logic          line_done = 1'b0;
  logic          next_line_clock_into_fifo, line_of_data_available, start_clocking_frame_data_cmd;
  logic          update, invert, underrun_err;
  logic [IW-1:0] line_index;
  logic [FW-1:0] frame_count;

  always #5 fpga_clk = ~fpga_clk;

  timing_controller_multiframe #(
    .BUF_CNT_W(BW), .WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF), .LINE_IDX_W(IW),
    .UPDATE_CYCLES(UC), .INVERT_PERIOD(IP), .LINE_TIMEOUT(LT), .FRAME_CNT_W(FW)
  ) dut (
    .fpga_clk(fpga_clk), .reset_all(reset_all), .enable(enable),
    .num_words_in_buffer(num_words_in_buffer), .dc32_fifo_is_empty(dc32_fifo_is_empty),
    .line_done(line_done), .next_line_clock_into_fifo(next_line_clock_into_fifo),
    .line_of_data_available(line_of_data_available),
    .start_clocking_frame_data_cmd(start_clocking_frame_data_cmd), .update(update),
    .invert(invert), .line_index(line_index), .frame_count(frame_count),
    .underrun_err(underrun_err)
  );

  int n_checks = 0, n_bad = 0;

  // behavioural model: phase of the frame plus plain integer bookkeeping
  int m_ph, m_idx, m_age, m_left, m_fc, m_since, m_prev, send_age;
  bit m_inv, m_err, m_start;

  typedef struct {
    logic ld; logic st; logic rq; logic la; logic up; logic iv; int ix; int fc;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(input logic ld, st, rq, la, up, iv, input int ix, fc);
    vec_t v;
    v.ld = ld; v.st = st; v.rq = rq; v.la = la; v.up = up; v.iv = iv; v.ix = ix; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_idx = 0; m_age = 0; m_left = 0; m_fc = 0; m_since = 0; m_prev = 0;
    send_age = 0; m_inv = 1'b0; m_err = 1'b0; m_start = 1'b0;
  endtask

  task automatic model_step();
    int nw;
    nw = int'(num_words_in_buffer);
    m_start = 1'b0;
    case (m_ph)
      P_IDLE: if (enable) begin m_ph = P_REQ; m_start = 1'b1; m_idx = 0; end
      P_REQ: begin m_age = 0; m_ph = P_WAIT; end
      P_WAIT: begin
        if (nw >= WPL) m_ph = P_SEND;
        else if (!(!dc32_fifo_is_empty && nw > m_prev)) begin
          if (m_age == LT - 1) begin m_err = 1'b1; m_idx = 0; m_ph = P_IDLE; end
          else m_age++;
        end
      end
      P_SEND: if (line_done) begin
        if (m_idx == LPF - 1) begin m_ph = P_UPD; m_left = UC; end
        else begin m_idx++; m_ph = P_REQ; end
      end
      P_UPD: begin
        m_left--;
        if (m_left == 0) begin
          m_fc = (m_fc + 1) % (1 << FW);
          m_since++;
          if (m_since == IP) begin m_inv = !m_inv; m_since = 0; end
          if (enable) begin m_ph = P_REQ; m_start = 1'b1; m_idx = 0; end
          else m_ph = P_IDLE;
        end
      end
      default: m_ph = P_IDLE;
    endcase
    m_prev = nw;
    send_age = (m_ph == P_SEND) ? send_age + 1 : 0;
  endtask

  task automatic compare_model();
    check("start", 32'(start_clocking_frame_data_cmd), 32'(m_start));
    check("req", 32'(next_line_clock_into_fifo), 32'(m_ph == P_REQ));
    check("lda", 32'(line_of_data_available), 32'(m_ph == P_SEND));
    check("update", 32'(update), 32'(m_ph == P_UPD));
    check("invert", 32'(invert), 32'(m_inv));
    check("line_index", 32'(line_index), 32'(m_idx));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("underrun_err", 32'(underrun_err), 32'(m_err));
  endtask

  task automatic run_cycle();
    @(posedge fpga_clk);
    model_step();
    @(negedge fpga_clk);
  endtask

  task automatic cycle_chk();
    run_cycle();
    compare_model();
  endtask

  task automatic run_until_fc(input int target, input bit en_val);
    int budget;
    budget = 400;
    while (m_fc != target && budget > 0) begin
      enable = en_val;
      line_done = (send_age >= 2);
      cycle_chk();
      budget--;
    end
    line_done = 1'b0;
    check("frame_reached", 32'(frame_count), 32'(target));
  endtask

  task automatic run_to_idle();
    int budget;
    budget = 400;
    enable = 1'b0;
    while (m_ph != P_IDLE && budget > 0) begin
      line_done = (send_age >= 2);
      cycle_chk();
      budget--;
    end
    line_done = 1'b0;
    check("idle_reached", 32'(budget > 0), 32'(1));
  endtask

  initial begin
    int cnt, budget, starts;
    model_reset();
    tbl[0]  = mk(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 1, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 2, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 2, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 2, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 2, 0);
    tbl[12] = mk(1, 0, 0, 0, 1, 0, 2, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 2, 0);
    tbl[14] = mk(0, 1, 1, 0, 0, 1, 0, 1);

    // reset state
    repeat (3) @(negedge fpga_clk);
    compare_model();
    reset_all = 1'b0;

    // first frame from the vector table
    enable = 1'b1; num_words_in_buffer = 4'd4; dc32_fifo_is_empty = 1'b0;
    for (int i = 0; i < 15; i++) begin
      line_done = tbl[i].ld;
      run_cycle();
      check($sformatf("tbl%0d_start", i), 32'(start_clocking_frame_data_cmd), 32'(tbl[i].st));
      check($sformatf("tbl%0d_req", i), 32'(next_line_clock_into_fifo), 32'(tbl[i].rq));
      check($sformatf("tbl%0d_lda", i), 32'(line_of_data_available), 32'(tbl[i].la));
      check($sformatf("tbl%0d_update", i), 32'(update), 32'(tbl[i].up));
      check($sformatf("tbl%0d_invert", i), 32'(invert), 32'(tbl[i].iv));
      check($sformatf("tbl%0d_index", i), 32'(line_index), 32'(tbl[i].ix));
      check($sformatf("tbl%0d_fc", i), 32'(frame_count), 32'(tbl[i].fc));
      check($sformatf("tbl%0d_err", i), 32'(underrun_err), 32'(0));
    end
    line_done = 1'b0;

    // three back-to-back frames: invert toggles every frame, restart right after update
    for (int f = 2; f <= 4; f++) begin
      run_until_fc(f, 1'b1);
      check("frame_invert", 32'(invert), 32'(f % 2));
      check("restart_pulse", 32'(start_clocking_frame_data_cmd), 32'(1));
      check("update_fallen", 32'(update), 32'(0));
    end

    // slow fill: nothing released until the fill level is reached, no watchdog trip
    num_words_in_buffer = 4'd3;
    cycle_chk();
    for (int i = 0; i < 10; i++) begin
      cycle_chk();
      check("slow_fill_lda", 32'(line_of_data_available), 32'(0));
    end
    num_words_in_buffer = 4'd4;
    cycle_chk();
    check("fill_lda", 32'(line_of_data_available), 32'(1));
    check("fill_no_err", 32'(underrun_err), 32'(0));

    // enable dropped during line 1, stray line_done in REQ/WAIT
    budget = 100;
    while (m_idx != 1 && budget > 0) begin
      line_done = (send_age >= 2);
      cycle_chk();
      budget--;
    end
    enable = 1'b0;
    budget = 200;
    while (m_ph != P_IDLE && budget > 0) begin
      line_done = (m_ph == P_REQ) || (m_ph == P_WAIT) || (send_age >= 2);
      cycle_chk();
      budget--;
    end
    line_done = 1'b0;
    check("drop_fc", 32'(frame_count), 32'(5));
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      cycle_chk();
      starts += int'(start_clocking_frame_data_cmd);
    end
    check("idle_no_start", 32'(starts), 32'(0));

    // starvation watchdog
    num_words_in_buffer = 4'd0; dc32_fifo_is_empty = 1'b1; enable = 1'b1;
    cycle_chk();
    enable = 1'b0;
    cnt = 0;
    while (underrun_err == 1'b0 && cnt < 40) begin
      cycle_chk();
      cnt++;
    end
    check("wait_clocks", 32'(cnt - 1), 32'(LT));
    check("timeout_index", 32'(line_index), 32'(0));
    for (int i = 0; i < 3; i++) begin
      cycle_chk();
      check("timeout_idle_req", 32'(next_line_clock_into_fifo), 32'(0));
    end
    num_words_in_buffer = 4'd4; dc32_fifo_is_empty = 1'b0;
    run_until_fc(6, 1'b1);
    check("err_sticky", 32'(underrun_err), 32'(1));
    run_to_idle();

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      num_words_in_buffer = ($urandom_range(0, 9) < 6) ? BW'($urandom_range(0, 3))
                                                       : BW'($urandom_range(4, 15));
      dc32_fifo_is_empty = 1'($urandom_range(0, 1));
      line_done = ($urandom_range(0, 3) == 0);
      cycle_chk();
    end

    // asynchronous reset mid-SEND
    enable = 1'b1; num_words_in_buffer = 4'd4; dc32_fifo_is_empty = 1'b0; line_done = 1'b0;
    budget = 100;
    while (m_ph != P_SEND && budget > 0) begin
      cycle_chk();
      budget--;
    end
    check("reached_send", 32'(line_of_data_available), 32'(1));
    #2 reset_all = 1'b1;
    #1 model_reset();
    compare_model();
    @(negedge fpga_clk);
    enable = 1'b0;
    reset_all = 1'b0;
    for (int i = 0; i < 5; i++) cycle_chk();
    run_until_fc(1, 1'b1);
    run_to_idle();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
